// File: rtl/qam_symbol_sequencer_if.sv
// Handshake and strobe bundle between the serial bit source / S2P front end
// and the QAM symbol sequencer.
interface qam_symbol_sequencer_if;
    logic       bit_valid;
    logic       bit_ready;
    logic       data_ready;
    logic       data_change;
    logic [2:0] bit_index;
    logic       symbol_strobe;
    logic       sym_update;

    // Bit source / S2P side
    modport master (
        output bit_valid,
        input  bit_ready, data_ready, data_change, bit_index, symbol_strobe, sym_update
    );

    // Sequencer side
    modport slave (
        input  bit_valid,
        output bit_ready, data_ready, data_change, bit_index, symbol_strobe, sym_update
    );
endinterface

// File: rtl/qam_symbol_sequencer.sv
// QAM symbol sequencer: pulls serial bits into S2P at a fixed symbol cadence,
// marks symbol boundaries and counts symbols that finished late.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | stopped; period counter parked at 0
// WAIT_BIT | bit_ready high, waiting for the source to present a bit
// ADVANCE  | one-cycle data_change strobe, bit_index steps
// HOLD     | symbol complete early, waiting for the period boundary
module qam_symbol_sequencer #(
    parameter int BITS_PER_SYMBOL = 2,
    parameter int SYMBOL_PERIOD   = 16,
    parameter int CNT_W           = 8
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic                   enable_i,
    qam_symbol_sequencer_if.slave  sif,
    output logic                   busy_o,
    output logic [7:0]             underrun_cnt_o
);

    typedef enum logic [1:0] {IDLE, WAIT_BIT, ADVANCE, HOLD} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYMBOL_PERIOD - 1);
    localparam logic [2:0]       IDX_LAST = 3'(BITS_PER_SYMBOL - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       idx_q, idx_d;
    logic             late_q, late_d;
    logic [7:0]       ur_q, ur_d;
    logic             su1_q, su2_q;

    logic strobe;
    logic adv_last;
    logic underrun;

    assign strobe   = (cnt_q == CNT_LAST);
    assign adv_last = (state_q == ADVANCE) && (idx_q == IDX_LAST);

    // Next-state, period counter, bit index and underrun bookkeeping
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        late_d   = late_q;
        ur_d     = ur_q;
        underrun = 1'b0;

        if (state_q != IDLE) begin
            cnt_d = strobe ? '0 : cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (enable_i) state_d = WAIT_BIT;
            end
            WAIT_BIT: begin
                if (sif.bit_valid) state_d = ADVANCE;
                underrun = strobe;
            end
            ADVANCE: begin
                if (idx_q != IDX_LAST) begin
                    idx_d    = idx_q + 3'd1;
                    state_d  = WAIT_BIT;
                    underrun = strobe;
                end else begin
                    idx_d = '0;
                    if (late_q) begin
                        // Late symbol just completed: catch up without holding.
                        late_d  = 1'b0;
                        state_d = enable_i ? WAIT_BIT : IDLE;
                    end else if (strobe) begin
                        state_d = enable_i ? WAIT_BIT : IDLE;
                    end else begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (strobe) state_d = enable_i ? WAIT_BIT : IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A late symbol is still finished so S2P slot alignment is preserved.
        if (underrun) begin
            late_d = 1'b1;
            if (ur_q != 8'hFF) ur_d = ur_q + 8'd1;
        end

        if (state_d == IDLE) cnt_d = '0;
    end

    // Single register bank for the FSM and its bookkeeping
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            late_q  <= 1'b0;
            ur_q    <= '0;
            su1_q   <= 1'b0;
            su2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            late_q  <= late_d;
            ur_q    <= ur_d;
            // Two stages to line up with S2P's counter-then-output registers.
            su1_q   <= adv_last;
            su2_q   <= su1_q;
        end
    end

    assign sif.bit_ready     = (state_q == WAIT_BIT);
    assign sif.data_ready    = sif.bit_valid & (state_q == WAIT_BIT);
    assign sif.data_change   = (state_q == ADVANCE);
    assign sif.bit_index     = idx_q;
    assign sif.symbol_strobe = strobe;
    assign sif.sym_update    = su2_q;
    assign busy_o            = (state_q != IDLE);
    assign underrun_cnt_o    = ur_q;

endmodule
